switch_alloc: RTL and testbench

Five-port wormhole switch allocator for the NoC router; sits between the input buffers and the crossbar, directly beside the flow-control-credit block (FCC). Each cycle it arbitrates input-port requests per output port (N, S, E, W, L), grants only outputs whose FCC `credit_en_*_o` is high, and pulses the matching `*_decr_i` into the FCC for every flit sent. An output stays locked to one input from head flit to tail flit. Port index encoding everywhere: N=0, S=1, E=2, W=3, L=4.

---
 rtl/switch_alloc.sv | 145 ++++++++++++++
 tb/tb_switch_alloc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_alloc.sv
// rtl/switch_alloc.sv - five-port wormhole switch allocator with credit gating
module switch_alloc #(
  parameter int NPORTS = 5,
  parameter int DW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_n_i,
  input  logic          req_s_i,
  input  logic          req_e_i,
  input  logic          req_w_i,
  input  logic          req_l_i,
  input  logic [DW-1:0] dest_n_i,
  input  logic [DW-1:0] dest_s_i,
  input  logic [DW-1:0] dest_e_i,
  input  logic [DW-1:0] dest_w_i,
  input  logic [DW-1:0] dest_l_i,
  input  logic          tail_n_i,
  input  logic          tail_s_i,
  input  logic          tail_e_i,
  input  logic          tail_w_i,
  input  logic          tail_l_i,
  input  logic          credit_en_north_i,
  input  logic          credit_en_south_i,
  input  logic          credit_en_east_i,
  input  logic          credit_en_west_i,
  input  logic          credit_en_local_i,
  output logic          gnt_n_o,
  output logic          gnt_s_o,
  output logic          gnt_e_o,
  output logic          gnt_w_o,
  output logic          gnt_l_o,
  output logic          n_decr_o,
  output logic          s_decr_o,
  output logic          e_decr_o,
  output logic          w_decr_o,
  output logic          l_decr_o,
  output logic [DW-1:0] xb_sel_n_o,
  output logic [DW-1:0] xb_sel_s_o,
  output logic [DW-1:0] xb_sel_e_o,
  output logic [DW-1:0] xb_sel_w_o,
  output logic [DW-1:0] xb_sel_l_o,
  output logic          xb_vld_n_o,
  output logic          xb_vld_s_o,
  output logic          xb_vld_e_o,
  output logic          xb_vld_w_o,
  output logic          xb_vld_l_o
);

  logic [NPORTS-1:0] req, tail, cred;
  logic [DW-1:0]     dest [NPORTS];

  assign req     = {req_l_i, req_w_i, req_e_i, req_s_i, req_n_i};
  assign tail    = {tail_l_i, tail_w_i, tail_e_i, tail_s_i, tail_n_i};
  assign cred    = {credit_en_local_i, credit_en_west_i, credit_en_east_i,
                    credit_en_south_i, credit_en_north_i};
  assign dest[0] = dest_n_i;
  assign dest[1] = dest_s_i;
  assign dest[2] = dest_e_i;
  assign dest[3] = dest_w_i;
  assign dest[4] = dest_l_i;

  // Per-output lock/owner/pointer plus the registered crossbar controls.
  logic [NPORTS-1:0] lock_q, lock_d;
  logic [NPORTS-1:0] xb_vld_q, xb_vld_d;
  logic [DW-1:0]     owner_q  [NPORTS];
  logic [DW-1:0]     owner_d  [NPORTS];
  logic [DW-1:0]     rr_ptr_q [NPORTS];
  logic [DW-1:0]     rr_ptr_d [NPORTS];
  logic [DW-1:0]     xb_sel_q [NPORTS];
  logic [DW-1:0]     xb_sel_d [NPORTS];

  logic [NPORTS-1:0] gnt, decr, hit;
  logic [DW-1:0]     win [NPORTS];
  logic [DW-1:0]     idx;

  // Round-robin search per output starting after the last winner; a locked
  // output only admits its owner, and no credit means no grant at all.
  always_comb begin
    gnt      = '0;
    decr     = '0;
    hit      = '0;
    idx      = '0;
    lock_d   = lock_q;
    xb_vld_d = '0;
    for (int o = 0; o < NPORTS; o++) begin
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      xb_sel_d[o] = xb_sel_q[o];
      win[o]      = '0;
      for (int k = 1; k <= NPORTS; k++) begin
        idx = DW'((int'(rr_ptr_q[o]) + k) % NPORTS);
        if (!hit[o] && cred[o] && req[idx] && (dest[idx] == DW'(o)) &&
            (!lock_q[o] || (owner_q[o] == idx))) begin
          hit[o] = 1'b1;
          win[o] = idx;
        end
      end
      if (hit[o]) begin
        decr[o]      = 1'b1;
        gnt[win[o]]  = 1'b1;
        rr_ptr_d[o]  = win[o];
        lock_d[o]    = !tail[win[o]];
        if (!tail[win[o]]) owner_d[o] = win[o];
        xb_vld_d[o]  = 1'b1;
        xb_sel_d[o]  = win[o];
      end
    end
    if (!rst_n) begin
      gnt  = '0;
      decr = '0;
    end
  end

  // State register; reset leaves every output free with north first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q   <= '0;
      xb_vld_q <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= DW'(NPORTS - 1);
        xb_sel_q[o] <= '0;
      end
    end else begin
      lock_q   <= lock_d;
      xb_vld_q <= xb_vld_d;
      for (int o = 0; o < NPORTS; o++) begin
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
        xb_sel_q[o] <= xb_sel_d[o];
      end
    end
  end

  assign {gnt_l_o, gnt_w_o, gnt_e_o, gnt_s_o, gnt_n_o}           = gnt;
  assign {l_decr_o, w_decr_o, e_decr_o, s_decr_o, n_decr_o}      = decr;
  assign {xb_vld_l_o, xb_vld_w_o, xb_vld_e_o, xb_vld_s_o, xb_vld_n_o} = xb_vld_q;
  assign xb_sel_n_o = xb_sel_q[0];
  assign xb_sel_s_o = xb_sel_q[1];
  assign xb_sel_e_o = xb_sel_q[2];
  assign xb_sel_w_o = xb_sel_q[3];
  assign xb_sel_l_o = xb_sel_q[4];

endmodule

// File: tb/tb_switch_alloc.sv
// tb/tb_switch_alloc.sv - vector table, corner sequences and random model check
module tb_switch_alloc;

  logic       clk, rst_n;
  logic [4:0] req, tail, cred;
  logic [2:0] dv [5];
  logic [4:0] gnt, decr, xvld;
  logic [2:0] xsel [5];
  int         total, bad;

  switch_alloc dut (
    .clk(clk), .rst_n(rst_n),
    .req_n_i(req[0]), .req_s_i(req[1]), .req_e_i(req[2]), .req_w_i(req[3]), .req_l_i(req[4]),
    .dest_n_i(dv[0]), .dest_s_i(dv[1]), .dest_e_i(dv[2]), .dest_w_i(dv[3]), .dest_l_i(dv[4]),
    .tail_n_i(tail[0]), .tail_s_i(tail[1]), .tail_e_i(tail[2]), .tail_w_i(tail[3]), .tail_l_i(tail[4]),
    .credit_en_north_i(cred[0]), .credit_en_south_i(cred[1]), .credit_en_east_i(cred[2]),
    .credit_en_west_i(cred[3]), .credit_en_local_i(cred[4]),
    .gnt_n_o(gnt[0]), .gnt_s_o(gnt[1]), .gnt_e_o(gnt[2]), .gnt_w_o(gnt[3]), .gnt_l_o(gnt[4]),
    .n_decr_o(decr[0]), .s_decr_o(decr[1]), .e_decr_o(decr[2]), .w_decr_o(decr[3]), .l_decr_o(decr[4]),
    .xb_sel_n_o(xsel[0]), .xb_sel_s_o(xsel[1]), .xb_sel_e_o(xsel[2]), .xb_sel_w_o(xsel[3]), .xb_sel_l_o(xsel[4]),
    .xb_vld_n_o(xvld[0]), .xb_vld_s_o(xvld[1]), .xb_vld_e_o(xvld[2]), .xb_vld_w_o(xvld[3]), .xb_vld_l_o(xvld[4])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [14:0] dest;
    logic [4:0]  tail;
    logic [4:0]  cred;
    logic [4:0]  gnt;
    logic [4:0]  decr;
    logic [2:0]  sel_e;
  } vec_t;

  vec_t tbl [15];

  // Reference model state: per-output lock, owner, last winner, crossbar regs.
  int         m_lock [5];
  int         m_owner [5];
  int         m_rr [5];
  logic [4:0] m_vld;
  logic [2:0] m_sel [5];

  function automatic logic [14:0] d5(int n, int s, int e, int w, int l);
    return {3'(l), 3'(w), 3'(e), 3'(s), 3'(n)};
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic [4:0] r, logic [14:0] d, logic [4:0] t, logic [4:0] c);
    req  = r;
    tail = t;
    cred = c;
    for (int p = 0; p < 5; p++) dv[p] = d[p*3 +: 3];
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_vld = '0;
    for (int o = 0; o < 5; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_rr[o] = 4; m_sel[o] = '0;
    end
  endtask

  // Model step: decide winner of each output from the rules, compare, advance.
  task automatic model_check();
    int         w [5];
    logic [4:0] eg, ed;
    eg = '0; ed = '0;
    for (int o = 0; o < 5; o++) begin
      w[o] = -1;
      if (cred[o]) begin
        if (m_lock[o] != 0) begin
          if (req[m_owner[o]] && int'(dv[m_owner[o]]) == o) w[o] = m_owner[o];
        end else begin
          for (int k = 1; k <= 5 && w[o] < 0; k++) begin
            int p;
            p = (m_rr[o] + k) % 5;
            if (req[p] && int'(dv[p]) == o) w[o] = p;
          end
        end
      end
      if (w[o] >= 0) begin eg[w[o]] = 1'b1; ed[o] = 1'b1; end
    end
    chk("rnd_gnt", int'(gnt), int'(eg));
    chk("rnd_decr", int'(decr), int'(ed));
    chk("rnd_xb_vld", int'(xvld), int'(m_vld));
    for (int o = 0; o < 5; o++) chk("rnd_xb_sel", int'(xsel[o]), int'(m_sel[o]));
    for (int o = 0; o < 5; o++) begin
      m_vld[o] = (w[o] >= 0);
      if (w[o] >= 0) begin
        m_sel[o] = 3'(w[o]);
        m_rr[o]  = w[o];
        m_lock[o] = tail[w[o]] ? 0 : 1;
        if (!tail[w[o]]) m_owner[o] = w[o];
      end
    end
  endtask

  initial begin
    logic [4:0] prev_decr;
    total = 0; bad = 0;
    rst_n = 1'b0;
    drive('0, '0, '0, '0);

    //                rst   req       dest             tail      cred      gnt       decr      sel_e
    tbl[0]  = '{1'b1, 5'b00000, d5(0,0,0,0,0), 5'b11111, 5'b11111, 5'b00000, 5'b00000, 3'd0};
    tbl[1]  = '{1'b0, 5'b01000, d5(0,0,0,2,0), 5'b11111, 5'b11111, 5'b01000, 5'b00100, 3'd0};
    tbl[2]  = '{1'b0, 5'b00000, d5(0,0,0,0,0), 5'b11111, 5'b11111, 5'b00000, 5'b00000, 3'd3};
    tbl[3]  = '{1'b1, 5'b10011, d5(2,2,0,0,2), 5'b11111, 5'b11111, 5'b00001, 5'b00100, 3'd0};
    tbl[4]  = '{1'b0, 5'b10011, d5(2,2,0,0,2), 5'b11111, 5'b11111, 5'b00010, 5'b00100, 3'd0};
    tbl[5]  = '{1'b0, 5'b10011, d5(2,2,0,0,2), 5'b11111, 5'b11111, 5'b10000, 5'b00100, 3'd1};
    tbl[6]  = '{1'b0, 5'b10011, d5(2,2,0,0,2), 5'b11111, 5'b11111, 5'b00001, 5'b00100, 3'd4};
    tbl[7]  = '{1'b1, 5'b01010, d5(0,4,0,4,0), 5'b00000, 5'b11111, 5'b00010, 5'b10000, 3'd0};
    tbl[8]  = '{1'b0, 5'b01010, d5(0,4,0,4,0), 5'b00000, 5'b11111, 5'b00010, 5'b10000, 3'd0};
    tbl[9]  = '{1'b0, 5'b01010, d5(0,4,0,4,0), 5'b00010, 5'b11111, 5'b00010, 5'b10000, 3'd0};
    tbl[10] = '{1'b0, 5'b01000, d5(0,4,0,4,0), 5'b00000, 5'b11111, 5'b01000, 5'b10000, 3'd0};
    tbl[11] = '{1'b1, 5'b00111, d5(1,0,6,0,0), 5'b11111, 5'b11111, 5'b00011, 5'b00011, 3'd0};
    tbl[12] = '{1'b0, 5'b00100, d5(0,0,6,0,0), 5'b11111, 5'b11111, 5'b00000, 5'b00000, 3'd0};
    tbl[13] = '{1'b0, 5'b10100, d5(0,0,7,0,4), 5'b11111, 5'b11111, 5'b10000, 5'b10000, 3'd0};
    tbl[14] = '{1'b0, 5'b00001, d5(1,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 3'd0};

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_xb_vld", int'(xvld), 0);
    chk("reset_gnt", int'(gnt), 0);
    @(posedge clk); #1;

    prev_decr = '0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) begin
        pulse_reset();
        prev_decr = '0;
      end
      drive(tbl[i].req, tbl[i].dest, tbl[i].tail, tbl[i].cred);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("vec%0d_decr", i), int'(decr), int'(tbl[i].decr));
      chk($sformatf("vec%0d_xb_vld", i), int'(xvld), int'(prev_decr));
      if (prev_decr[2]) chk($sformatf("vec%0d_xb_sel_e", i), int'(xsel[2]), int'(tbl[i].sel_e));
      prev_decr = tbl[i].decr;
      @(posedge clk); #1;
    end

    // Credit stall on a locked N->W packet while S also wants W.
    pulse_reset();
    drive(5'b00011, d5(3,3,0,0,0), 5'b00000, 5'b11111);
    @(negedge clk);
    chk("stall_head_gnt", int'(gnt), 1);
    chk("stall_head_decr", int'(decr), 8);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      cred = 5'b10111;
      @(negedge clk);
      chk("stall_gnt", int'(gnt), 0);
      chk("stall_w_decr", int'(decr[3]), 0);
    end
    @(posedge clk); #1;
    cred = 5'b11111;
    @(negedge clk);
    chk("stall_resume_gnt", int'(gnt), 1);
    chk("stall_resume_decr", int'(decr), 8);
    @(posedge clk); #1;
    tail = 5'b00001;
    @(negedge clk);
    chk("stall_tail_gnt", int'(gnt), 1);
    @(posedge clk); #1;
    drive(5'b00010, d5(0,3,0,0,0), 5'b00000, 5'b11111);
    @(negedge clk);
    chk("stall_next_owner", int'(gnt), 2);
    chk("stall_xb_sel_w", int'(xsel[3]), 0);
    @(posedge clk); #1;

    // Reset while output E is locked to N.
    pulse_reset();
    drive(5'b00001, d5(2,0,0,0,0), 5'b00000, 5'b11111);
    @(negedge clk);
    chk("mid_head_gnt", int'(gnt), 1);
    @(posedge clk); #1;
    chk("mid_xb_vld_e", int'(xvld), 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_xb_vld", int'(xvld), 0);
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_decr", int'(decr), 0);
    #1;
    rst_n = 1'b1;
    drive(5'b10000, d5(0,0,0,0,2), 5'b00000, 5'b11111);
    @(negedge clk);
    chk("mid_new_owner_gnt", int'(gnt), 16);
    chk("mid_new_owner_decr", int'(decr), 4);
    @(posedge clk); #1;

    // Randomised run against the reference model.
    pulse_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req = 5'($urandom);
      for (int p = 0; p < 5; p++) begin
        dv[p]   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        tail[p] = ($urandom_range(0, 3) == 0);
        cred[p] = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);
      model_check();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
